id_ex_stage: RTL and testbench

//  ID/EX pipeline register of the TaoShuRV core; sole source of alu_ctrl/alu_src1/alu_src2 for the ALU.

---
 rtl/id_ex_stage_if.sv | 57 +++++
 rtl/id_ex_stage.sv | 123 ++++++++++++
 tb/tb_id_ex_stage.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode/forwarding/ALU-side bundle of the ID/EX pipeline register
interface id_ex_stage_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            id_valid;
  logic            id_ready;
  logic [XLEN-1:0] id_pc;
  logic [4:0]      id_rs1_idx;
  logic [4:0]      id_rs2_idx;
  logic            id_rs1_used;
  logic            id_rs2_used;
  logic [XLEN-1:0] id_rs1_data;
  logic [XLEN-1:0] id_rs2_data;
  logic [XLEN-1:0] id_imm;
  logic [1:0]      id_src1_sel;
  logic [1:0]      id_src2_sel;
  logic [3:0]      id_alu_ctrl;
  logic [4:0]      id_rd;
  logic            id_wb_en;
  logic            id_mem_rd;
  logic [XLEN-1:0] ex_alu_result;
  logic            mem_fwd_en;
  logic [4:0]      mem_fwd_rd;
  logic [XLEN-1:0] mem_fwd_data;
  logic            wb_fwd_en;
  logic [4:0]      wb_fwd_rd;
  logic [XLEN-1:0] wb_fwd_data;
  logic            ex_valid;
  logic            ex_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_src1;
  logic [XLEN-1:0] alu_src2;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs2_data;
  logic [4:0]      ex_rd;
  logic            ex_wb_en;
  logic            ex_mem_rd;

  modport master (
    output flush, id_valid, id_pc, id_rs1_idx, id_rs2_idx, id_rs1_used, id_rs2_used,
           id_rs1_data, id_rs2_data, id_imm, id_src1_sel, id_src2_sel, id_alu_ctrl,
           id_rd, id_wb_en, id_mem_rd, ex_alu_result, mem_fwd_en, mem_fwd_rd,
           mem_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data, ex_ready,
    input  id_ready, ex_valid, alu_ctrl, alu_src1, alu_src2, ex_pc, ex_rs2_data,
           ex_rd, ex_wb_en, ex_mem_rd
  );

  modport slave (
    input  flush, id_valid, id_pc, id_rs1_idx, id_rs2_idx, id_rs1_used, id_rs2_used,
           id_rs1_data, id_rs2_data, id_imm, id_src1_sel, id_src2_sel, id_alu_ctrl,
           id_rd, id_wb_en, id_mem_rd, ex_alu_result, mem_fwd_en, mem_fwd_rd,
           mem_fwd_data, wb_fwd_en, wb_fwd_rd, wb_fwd_data, ex_ready,
    output id_ready, ex_valid, alu_ctrl, alu_src1, alu_src2, ex_pc, ex_rs2_data,
           ex_rd, ex_wb_en, ex_mem_rd
  );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding, load-use bubble and flush; optional ID_EX_PERF_EN perf counters
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          rst_n,
  id_ex_stage_if.slave bus
`ifdef ID_EX_PERF_EN
  ,
  output logic [31:0]  perf_bubble_cnt,
  output logic [31:0]  perf_stall_cnt
`endif
);

  // Youngest writer wins; x0 is hard-wired zero so nothing may forward into it.
  function automatic logic [XLEN-1:0] fwd_pick(
    input logic [4:0]      idx,
    input logic [XLEN-1:0] rf_data,
    input logic            ex_en,
    input logic [4:0]      ex_rd,
    input logic [XLEN-1:0] ex_data,
    input logic            mem_en,
    input logic [4:0]      mem_rd,
    input logic [XLEN-1:0] mem_data,
    input logic            wb_en,
    input logic [4:0]      wb_rd,
    input logic [XLEN-1:0] wb_data
  );
    logic [XLEN-1:0] v;
    if (idx == 5'd0)                     v = '0;
    else if (ex_en && (ex_rd == idx))   v = ex_data;
    else if (mem_en && (mem_rd == idx)) v = mem_data;
    else if (wb_en && (wb_rd == idx))   v = wb_data;
    else                                v = rf_data;
    return v;
  endfunction

  logic            ex_fwd_en;
  logic            load_use;
  logic            adv;
  logic            capture;
  logic [XLEN-1:0] rs1_fwd;
  logic [XLEN-1:0] rs2_fwd;
  logic [XLEN-1:0] src1_nxt;
  logic [XLEN-1:0] src2_nxt;

  // A held load has no result yet, so it cannot be an EX forward source.
  assign ex_fwd_en = bus.ex_valid & bus.ex_wb_en & ~bus.ex_mem_rd;

  assign rs1_fwd = fwd_pick(bus.id_rs1_idx, bus.id_rs1_data, ex_fwd_en, bus.ex_rd, bus.ex_alu_result,
                            bus.mem_fwd_en, bus.mem_fwd_rd, bus.mem_fwd_data,
                            bus.wb_fwd_en, bus.wb_fwd_rd, bus.wb_fwd_data);
  assign rs2_fwd = fwd_pick(bus.id_rs2_idx, bus.id_rs2_data, ex_fwd_en, bus.ex_rd, bus.ex_alu_result,
                            bus.mem_fwd_en, bus.mem_fwd_rd, bus.mem_fwd_data,
                            bus.wb_fwd_en, bus.wb_fwd_rd, bus.wb_fwd_data);

  assign load_use = bus.ex_valid & bus.ex_mem_rd & (bus.ex_rd != 5'd0) &
                    ((bus.id_rs1_used & (bus.id_rs1_idx == bus.ex_rd)) |
                     (bus.id_rs2_used & (bus.id_rs2_idx == bus.ex_rd)));
  assign adv          = ~bus.ex_valid | bus.ex_ready;
  assign bus.id_ready = adv & ~load_use & ~bus.flush;
  assign capture      = bus.id_valid & bus.id_ready;

  // Operand selection, resolved once at capture time.
  always_comb begin
    src1_nxt = '0;
    src2_nxt = '0;
    case (bus.id_src1_sel)
      2'd0:    src1_nxt = rs1_fwd;
      2'd1:    src1_nxt = bus.id_pc;
      default: src1_nxt = '0;
    endcase
    case (bus.id_src2_sel)
      2'd0:    src2_nxt = rs2_fwd;
      2'd1:    src2_nxt = bus.id_imm;
      2'd2:    src2_nxt = XLEN'(4);
      default: src2_nxt = '0;
    endcase
  end

  // Pipeline register: flush kills, capture loads, idle advance bubbles, otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ex_valid    <= 1'b0;
      bus.alu_ctrl    <= 4'h0;
      bus.alu_src1    <= '0;
      bus.alu_src2    <= '0;
      bus.ex_pc       <= '0;
      bus.ex_rs2_data <= '0;
      bus.ex_rd       <= 5'd0;
      bus.ex_wb_en    <= 1'b0;
      bus.ex_mem_rd   <= 1'b0;
    end else if (bus.flush) begin
      bus.ex_valid <= 1'b0;
    end else if (capture) begin
      bus.ex_valid    <= 1'b1;
      bus.alu_ctrl    <= bus.id_alu_ctrl;
      bus.alu_src1    <= src1_nxt;
      bus.alu_src2    <= src2_nxt;
      bus.ex_pc       <= bus.id_pc;
      bus.ex_rs2_data <= rs2_fwd;
      bus.ex_rd       <= bus.id_rd;
      bus.ex_wb_en    <= bus.id_wb_en;
      bus.ex_mem_rd   <= bus.id_mem_rd;
    end else if (adv) begin
      bus.ex_valid <= 1'b0;
    end
  end

`ifdef ID_EX_PERF_EN
  // Count load-use bubbles and downstream back-pressure cycles; both wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubble_cnt <= 32'd0;
      perf_stall_cnt  <= 32'd0;
    end else begin
      if (adv & load_use & bus.id_valid & ~bus.flush) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      if (bus.ex_valid & ~bus.ex_ready)               perf_stall_cnt  <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - self-checking bench for id_ex_stage with a behavioural reference model
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fails = 0;

  id_ex_stage_if #(.XLEN(32)) bus ();

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt;
  logic [31:0] stall_cnt;
  id_ex_stage #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                                .perf_bubble_cnt(bubble_cnt), .perf_stall_cnt(stall_cnt));
`else
  id_ex_stage #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  always #5 clk = ~clk;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] r2;
    logic [4:0]  rd;
    logic        wb;
    logic        mr;
    logic [3:0]  ac;
  } m_t;

  m_t m;

  function automatic logic [31:0] m_fwd(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return 32'd0;
    if (m.v && m.wb && !m.mr && m.rd == idx) return bus.ex_alu_result;
    if (bus.mem_fwd_en && bus.mem_fwd_rd == idx) return bus.mem_fwd_data;
    if (bus.wb_fwd_en && bus.wb_fwd_rd == idx) return bus.wb_fwd_data;
    return rf;
  endfunction

  function automatic logic m_ready();
    logic waits_on_load;
    waits_on_load = m.v && m.mr && m.rd != 0 &&
                    ((bus.id_rs1_used && bus.id_rs1_idx == m.rd) ||
                     (bus.id_rs2_used && bus.id_rs2_idx == m.rd));
    return (!m.v || bus.ex_ready) && !waits_on_load && !bus.flush;
  endfunction

  task automatic step();
    m_t n;
    logic [31:0] t1 [4];
    logic [31:0] t2 [4];
    n = m;
    t1 = '{m_fwd(bus.id_rs1_idx, bus.id_rs1_data), bus.id_pc, 32'd0, 32'd0};
    t2 = '{m_fwd(bus.id_rs2_idx, bus.id_rs2_data), bus.id_imm, 32'd4, 32'd0};
    if (bus.flush) n.v = 1'b0;
    else if (bus.id_valid && m_ready()) begin
      n.v  = 1'b1;
      n.pc = bus.id_pc;
      n.s1 = t1[bus.id_src1_sel];
      n.s2 = t2[bus.id_src2_sel];
      n.r2 = t1[0] == 32'd0 ? t2[0] : t2[0];
      n.rd = bus.id_rd;
      n.wb = bus.id_wb_en;
      n.mr = bus.id_mem_rd;
      n.ac = bus.id_alu_ctrl;
    end else if (!m.v || bus.ex_ready) n.v = 1'b0;
    @(posedge clk);
    m = n;
    #1;
  endtask

  task automatic clear_in();
    bus.flush = 0; bus.id_valid = 0; bus.ex_ready = 1; bus.ex_alu_result = 0;
    bus.mem_fwd_en = 0; bus.mem_fwd_rd = 0; bus.mem_fwd_data = 0;
    bus.wb_fwd_en = 0; bus.wb_fwd_rd = 0; bus.wb_fwd_data = 0;
    bus.id_pc = 0; bus.id_rs1_idx = 0; bus.id_rs2_idx = 0; bus.id_rs1_used = 0; bus.id_rs2_used = 0;
    bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0; bus.id_src1_sel = 0; bus.id_src2_sel = 0;
    bus.id_alu_ctrl = 0; bus.id_rd = 0; bus.id_wb_en = 0; bus.id_mem_rd = 0;
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [4:0] r1, input logic [4:0] r2,
                           input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                           input logic [1:0] s1, input logic [1:0] s2, input logic [3:0] ac,
                           input logic [4:0] rd, input logic wb, input logic mr);
    bus.id_valid = 1; bus.id_pc = pc; bus.id_rs1_idx = r1; bus.id_rs2_idx = r2;
    bus.id_rs1_used = 1; bus.id_rs2_used = 1; bus.id_rs1_data = d1; bus.id_rs2_data = d2;
    bus.id_imm = imm; bus.id_src1_sel = s1; bus.id_src2_sel = s2; bus.id_alu_ctrl = ac;
    bus.id_rd = rd; bus.id_wb_en = wb; bus.id_mem_rd = mr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    clear_in();
    m = '0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    clear_in();
    m = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.ex_valid, bus.alu_ctrl, bus.alu_src1, bus.alu_src2, bus.ex_pc, bus.ex_rs2_data,
         bus.ex_rd, bus.ex_wb_en, bus.ex_mem_rd} !== '0) begin
      n_fails++;
      $display("FAIL reset_regs: got valid=%0b ctrl=%h src1=%h src2=%h pc=%h, want all 0",
               bus.ex_valid, bus.alu_ctrl, bus.alu_src1, bus.alu_src2, bus.ex_pc);
    end
    rst_n = 1;
  endtask

  task automatic test_basic();
    @(negedge clk);
    clear_in();
    set_instr(32'h10, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0, 2'd0, 2'd0, 4'h0, 5'd9, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (bus.id_ready !== 1'b1) begin n_fails++; $display("FAIL basic_ready: got %b want 1", bus.id_ready); end
    step();
    n_checks++;
    if ({bus.ex_valid, bus.alu_src1, bus.alu_src2} !== {1'b1, 32'd5, 32'd7}) begin
      n_fails++;
      $display("FAIL basic_capture: got v=%b s1=%h s2=%h want v=1 s1=5 s2=7", bus.ex_valid, bus.alu_src1, bus.alu_src2);
    end
  endtask

  task automatic test_ex_priority();
    @(negedge clk);
    clear_in();
    set_instr(32'h20, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 2'd0, 2'd0, 4'h0, 5'd3, 1'b1, 1'b0);
    step();
    @(negedge clk);
    set_instr(32'h24, 5'd3, 5'd3, 32'h99, 32'h99, 32'd0, 2'd0, 2'd0, 4'h0, 5'd0, 1'b0, 1'b0);
    bus.ex_alu_result = 32'h10;
    bus.mem_fwd_en = 1; bus.mem_fwd_rd = 3; bus.mem_fwd_data = 32'h20;
    bus.wb_fwd_en = 1; bus.wb_fwd_rd = 3; bus.wb_fwd_data = 32'h30;
    step();
    n_checks++;
    if (bus.alu_src1 !== 32'h10) begin n_fails++; $display("FAIL fwd_ex_prio: got %h want 10", bus.alu_src1); end
    @(negedge clk);
    bus.id_pc = 32'h28;
    step();
    n_checks++;
    if (bus.alu_src1 !== 32'h20) begin n_fails++; $display("FAIL fwd_mem_prio: got %h want 20", bus.alu_src1); end
    @(negedge clk);
    bus.mem_fwd_en = 0;
    step();
    n_checks++;
    if (bus.ex_rs2_data !== 32'h30) begin n_fails++; $display("FAIL fwd_wb: got %h want 30", bus.ex_rs2_data); end
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_in();
    set_instr(32'h40, 5'd1, 5'd2, 32'd0, 32'd0, 32'd8, 2'd0, 2'd1, 4'h0, 5'd4, 1'b1, 1'b1);
    step();
    @(negedge clk);
    set_instr(32'h44, 5'd1, 5'd4, 32'd1, 32'h77, 32'd0, 2'd0, 2'd0, 4'h0, 5'd5, 1'b1, 1'b0);
    #1;
    n_checks++;
    if (bus.id_ready !== 1'b0) begin n_fails++; $display("FAIL lu_ready_low: got %b want 0", bus.id_ready); end
    step();
    n_checks++;
    if (bus.ex_valid !== 1'b0) begin n_fails++; $display("FAIL lu_bubble: got valid=%b want 0", bus.ex_valid); end
    @(negedge clk);
    bus.mem_fwd_en = 1; bus.mem_fwd_rd = 4; bus.mem_fwd_data = 32'hABCD0123;
    #1;
    n_checks++;
    if (bus.id_ready !== 1'b1) begin n_fails++; $display("FAIL lu_ready_back: got %b want 1", bus.id_ready); end
    step();
    n_checks++;
    if ({bus.ex_valid, bus.alu_src2, bus.ex_rs2_data} !== {1'b1, 32'hABCD0123, 32'hABCD0123}) begin
      n_fails++;
      $display("FAIL lu_accept: got v=%b s2=%h rs2=%h want v=1 s2=abcd0123 rs2=abcd0123",
               bus.ex_valid, bus.alu_src2, bus.ex_rs2_data);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    clear_in();
    set_instr(32'h100, 5'd0, 5'd9, 32'd0, 32'h99, 32'h55, 2'd1, 2'd1, 4'h3, 5'd6, 1'b1, 1'b0);
    step();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      set_instr(32'h200, 5'd1, 5'd9, 32'd1, 32'h1234 + i, 32'h66, 2'd0, 2'd2, 4'h5, 5'd7, 1'b1, 1'b0);
      bus.ex_ready = 0;
      #1;
      n_checks++;
      if (bus.id_ready !== 1'b0) begin n_fails++; $display("FAIL stall_ready: cycle %0d got %b want 0", i, bus.id_ready); end
      step();
      n_checks++;
      if ({bus.ex_valid, bus.ex_pc, bus.alu_src1, bus.alu_src2, bus.ex_rs2_data, bus.alu_ctrl} !==
          {1'b1, 32'h100, 32'h100, 32'h55, 32'h99, 4'h3}) begin
        n_fails++;
        $display("FAIL stall_hold: cycle %0d got v=%b pc=%h s1=%h s2=%h rs2=%h ctrl=%h want 1/100/100/55/99/3",
                 i, bus.ex_valid, bus.ex_pc, bus.alu_src1, bus.alu_src2, bus.ex_rs2_data, bus.alu_ctrl);
      end
    end
    @(negedge clk);
    bus.ex_ready = 1;
    #1;
    n_checks++;
    if (bus.id_ready !== 1'b1) begin n_fails++; $display("FAIL stall_release: got %b want 1", bus.id_ready); end
    step();
    n_checks++;
    if ({bus.ex_pc, bus.alu_src2} !== {32'h200, 32'd4}) begin
      n_fails++;
      $display("FAIL stall_next: got pc=%h s2=%h want pc=200 s2=4", bus.ex_pc, bus.alu_src2);
    end
  endtask

  task automatic test_flush();
    @(negedge clk);
    clear_in();
    set_instr(32'h300, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 2'd0, 2'd0, 4'h1, 5'd8, 1'b1, 1'b0);
    step();
    @(negedge clk);
    set_instr(32'h304, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0, 2'd0, 2'd0, 4'h1, 5'd8, 1'b1, 1'b0);
    bus.flush = 1; bus.ex_ready = 0;
    #1;
    n_checks++;
    if (bus.id_ready !== 1'b0) begin n_fails++; $display("FAIL flush_ready: got %b want 0", bus.id_ready); end
    step();
    n_checks++;
    if (bus.ex_valid !== 1'b0) begin n_fails++; $display("FAIL flush_kill: got valid=%b want 0", bus.ex_valid); end
    @(negedge clk);
    clear_in();
    set_instr(32'h308, 5'd0, 5'd0, 32'hFF, 32'hFF, 32'd0, 2'd0, 2'd0, 4'h0, 5'd0, 1'b0, 1'b0);
    bus.mem_fwd_en = 1; bus.mem_fwd_rd = 0; bus.mem_fwd_data = 32'hFF;
    bus.wb_fwd_en = 1; bus.wb_fwd_rd = 0; bus.wb_fwd_data = 32'hFF;
    step();
    n_checks++;
    if ({bus.ex_valid, bus.alu_src1, bus.alu_src2, bus.ex_rs2_data} !== {1'b1, 96'd0}) begin
      n_fails++;
      $display("FAIL x0_operand: got v=%b s1=%h s2=%h rs2=%h want v=1 and zeros",
               bus.ex_valid, bus.alu_src1, bus.alu_src2, bus.ex_rs2_data);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    clear_in();
    set_instr(32'h400, 5'd1, 5'd2, 32'd3, 32'd4, 32'd0, 2'd0, 2'd0, 4'h2, 5'd10, 1'b1, 1'b0);
    step();
    @(negedge clk);
    clear_in();
    #2;
    rst_n = 0;
    #1;
    n_checks++;
    if ({bus.ex_valid, bus.ex_pc} !== {1'b0, 32'd0}) begin
      n_fails++;
      $display("FAIL async_reset: got valid=%b pc=%h want 0/0", bus.ex_valid, bus.ex_pc);
    end
    m = '0;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      bus.flush = ($urandom_range(15) == 0);
      bus.id_valid = ($urandom_range(3) != 0);
      bus.ex_ready = ($urandom_range(3) != 0);
      bus.ex_alu_result = $urandom;
      bus.mem_fwd_en = $urandom_range(1); bus.mem_fwd_rd = 5'($urandom_range(7)); bus.mem_fwd_data = $urandom;
      bus.wb_fwd_en = $urandom_range(1); bus.wb_fwd_rd = 5'($urandom_range(7)); bus.wb_fwd_data = $urandom;
      bus.id_pc = $urandom; bus.id_imm = $urandom;
      bus.id_rs1_idx = 5'($urandom_range(7)); bus.id_rs2_idx = 5'($urandom_range(7));
      bus.id_rs1_used = $urandom_range(1); bus.id_rs2_used = $urandom_range(1);
      bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom;
      bus.id_src1_sel = 2'($urandom_range(3)); bus.id_src2_sel = 2'($urandom_range(3));
      bus.id_alu_ctrl = 4'($urandom_range(15)); bus.id_rd = 5'($urandom_range(7));
      bus.id_wb_en = $urandom_range(1); bus.id_mem_rd = ($urandom_range(2) == 0);
      #1;
      n_checks++;
      if (bus.id_ready !== m_ready()) begin
        n_fails++;
        $display("FAIL rand_ready: iter %0d got %b want %b", i, bus.id_ready, m_ready());
      end
      step();
      n_checks++;
      if ({bus.ex_valid, bus.ex_pc, bus.alu_src1, bus.alu_src2, bus.ex_rs2_data, bus.ex_rd,
           bus.ex_wb_en, bus.ex_mem_rd, bus.alu_ctrl} !== m) begin
        n_fails++;
        $display("FAIL rand_regs: iter %0d got v=%b pc=%h s1=%h s2=%h rs2=%h rd=%0d want v=%b pc=%h s1=%h s2=%h rs2=%h rd=%0d",
                 i, bus.ex_valid, bus.ex_pc, bus.alu_src1, bus.alu_src2, bus.ex_rs2_data, bus.ex_rd,
                 m.v, m.pc, m.s1, m.s2, m.r2, m.rd);
      end
    end
  endtask

`ifdef ID_EX_PERF_EN
  task automatic test_perf();
    do_reset();
    n_checks++;
    if ({bubble_cnt, stall_cnt} !== 64'd0) begin
      n_fails++;
      $display("FAIL perf_reset: got bubble=%0d stall=%0d want 0/0", bubble_cnt, stall_cnt);
    end
    test_load_use();
    n_checks++;
    if ({bubble_cnt, stall_cnt} !== {32'd1, 32'd0}) begin
      n_fails++;
      $display("FAIL perf_bubble: got bubble=%0d stall=%0d want 1/0", bubble_cnt, stall_cnt);
    end
    test_stall();
    n_checks++;
    if ({bubble_cnt, stall_cnt} !== {32'd1, 32'd3}) begin
      n_fails++;
      $display("FAIL perf_stall: got bubble=%0d stall=%0d want 1/3", bubble_cnt, stall_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ex_priority();
    test_load_use();
    test_stall();
    test_flush();
    test_async_reset();
    test_random();
`ifdef ID_EX_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
